// File: rtl/ahb_arbiter_if.sv
// Arbiter-side bus bundle: request/lock/transfer status in, grant and mux selects out.
// The slave modport is the arbiter's view; the master modport is the bus/master side.
interface ahb_arbiter_if;
    logic [2:0] hbusreq;
    logic [2:0] hlock;
    logic       hready;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic [2:0] hgrant;
    logic [1:0] addr_sel;
    logic [1:0] data_sel;
    logic       hmastlock;

    modport slave (
        input  hbusreq, hlock, hready, htrans, hburst,
        output hgrant, addr_sel, data_sel, hmastlock
    );

    modport master (
        output hbusreq, hlock, hready, htrans, hburst,
        input  hgrant, addr_sel, data_sel, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Three-master round-robin AHB arbiter with locked-transfer and fixed-length-burst protection.
// Drives the registered one-hot grant plus the address-phase and data-phase mux selects.
module ahb_arbiter #(
    parameter logic [1:0] MASTER1 = 2'b00,
    parameter logic [1:0] MASTER2 = 2'b01,
    parameter logic [1:0] MASTER3 = 2'b10
) (
    input  logic         hclk,
    input  logic         hreset,
    ahb_arbiter_if.slave bus
);

    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic [2:0] hgrant_q,    hgrant_d;
    logic [1:0] addr_sel_q,  addr_sel_d;
    logic [1:0] data_sel_q,  data_sel_d;
    logic       hmastlock_q, hmastlock_d;
    logic [3:0] cnt_q,       cnt_d;
    logic [1:0] rr_last_q,   rr_last_d;

    logic [1:0] owner_idx;
    logic [1:0] win_idx;
    logic       win_found;
    logic       locked;
    logic       rearb;
    int         start_i;
    int         cand_i;

    function automatic logic [1:0] enc_of(input logic [1:0] idx);
        case (idx)
            2'd1:    return MASTER2;
            2'd2:    return MASTER3;
            default: return MASTER1;
        endcase
    endfunction

    function automatic int idx_of(input logic [1:0] enc);
        if (enc == MASTER2) return 1;
        if (enc == MASTER3) return 2;
        return 0;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        cnt_d       = cnt_q;
        hgrant_d    = hgrant_q;
        rr_last_d   = rr_last_q;
        addr_sel_d  = addr_sel_q;
        data_sel_d  = data_sel_q;
        hmastlock_d = hmastlock_q;
        win_idx     = 2'd0;
        win_found   = 1'b0;
        cand_i      = 0;

        case (hgrant_q)
            3'b010:  owner_idx = 2'd1;
            3'b100:  owner_idx = 2'd2;
            default: owner_idx = 2'd0;
        endcase

        if (bus.hready) begin
            if (bus.htrans == TR_NONSEQ) begin
                case (bus.hburst)
                    3'b010, 3'b011: cnt_d = 4'd3;
                    3'b100, 3'b101: cnt_d = 4'd7;
                    3'b110, 3'b111: cnt_d = 4'd15;
                    default:        cnt_d = 4'd0;
                endcase
            end else if (bus.htrans == TR_SEQ && cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end
        end

        // Arbitrate only when no fixed-burst beats remain after this edge, which also
        // blocks the NONSEQ edge that starts a burst.
        locked = bus.hlock[owner_idx] & bus.hbusreq[owner_idx];
        rearb  = bus.hready && (cnt_d == 4'd0) && !locked;

        start_i = idx_of(rr_last_q);
        for (int k = 1; k <= 3; k++) begin
            cand_i = (start_i + k) % 3;
            if (!win_found && bus.hbusreq[cand_i]) begin
                win_found = 1'b1;
                win_idx   = 2'(cand_i);
            end
        end

        if (rearb) begin
            if (win_found) begin
                hgrant_d  = 3'b001 << win_idx;
                rr_last_d = enc_of(win_idx);
            end else begin
                hgrant_d  = 3'b001;
            end
        end

        if (bus.hready) begin
            addr_sel_d  = enc_of(owner_idx);
            hmastlock_d = bus.hlock[owner_idx];
            data_sel_d  = addr_sel_q;
        end
    end

    always_ff @(posedge hclk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (hreset) begin
            hgrant_q    <= 3'b001;
            addr_sel_q  <= MASTER1;
            data_sel_q  <= MASTER1;
            hmastlock_q <= 1'b0;
            cnt_q       <= 4'd0;
            rr_last_q   <= MASTER1;
        end else begin
            hgrant_q    <= hgrant_d;
            addr_sel_q  <= addr_sel_d;
            data_sel_q  <= data_sel_d;
            hmastlock_q <= hmastlock_d;
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign bus.hgrant    = hgrant_q;
    assign bus.addr_sel  = addr_sel_q;
    assign bus.data_sel  = data_sel_q;
    assign bus.hmastlock = hmastlock_q;

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Three-master AHB arbiter; decides bus ownership and drives the select lines for the address-phase and write-data muxes.
- data_sel connects directly to mux_sel of the write-data mux and uses the same 2-bit master encoding.
- addr_sel feeds the address/control mux.
- Round-robin policy with locked-transfer and fixed-length-burst protection.

Parameters:
- MASTER1, 2'b00, encoding for master 1 (default master)
- MASTER2, 2'b01, encoding for master 2
- MASTER3, 2'b10, encoding for master 3

Ports:
- hclk  input  1  bus clock; all state updates on rising edge
- hreset  input  1  synchronous, active-high reset
- hbusreq  input  3  bus requests; bit0=master1, bit1=master2, bit2=master3
- hlock  input  3  lock requests, same bit order
- hready  input  1  transfer-complete from slave mux
- htrans  input  2  HTRANS of the current address-phase master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- hburst  input  3  HBURST of the current address-phase master
- hgrant  output  3  one-hot grant, same bit order
- addr_sel  output  2  address-phase owner (HMASTER), encoded MASTERx
- data_sel  output  2  data-phase owner; drives the write-data mux select
- hmastlock  output  1  current address-phase transfer is locked

Behaviour:
- Reset (hreset=1 at an edge) sets:
  - hgrant=3'b001
  - addr_sel=MASTER1
  - data_sel=MASTER1
  - hmastlock=0
  - beat counter=0
  - rr_last=MASTER1
- Reset mid-transfer aborts all state to these values at the next edge. No output is ever X.
- Beat counter (4-bit) loads on any edge with hready=1 and htrans=NONSEQ:
  - INCR4/WRAP4 (011/010) load 3
  - INCR8/WRAP8 (101/100) load 7
  - INCR16/WRAP16 (111/110) load 15
  - SINGLE/INCR load 0
- Beat counter decrements on hready=1 and htrans=SEQ while >0.
- BUSY and IDLE do not change the count.
- Re-arbitration is permitted only when all of the following hold:
  - hready=1
  - beat counter is 0, or is 1 with htrans=SEQ (last beat)
  - the owner is not locked. Locked means hlock[owner]=1 and hbusreq[owner]=1.
- When re-arbitration is not permitted, hgrant holds.
- Round-robin: search from the master after rr_last, wrapping (rr_last=MASTER1 searches 2,3,1). The first master with hbusreq=1 is granted.
- If no master is requesting, grant the default master MASTER1.
- rr_last updates to the newly granted index only when a requesting master wins.
- hgrant is registered: a request seen at edge N gives hgrant at edge N+1, at the earliest.
- addr_sel takes the encoding of the hgrant bit on each edge with hready=1 and holds while hready=0.
- hmastlock updates to hlock[granted index] under the same condition as addr_sel.
- data_sel takes addr_sel on each edge with hready=1 and holds while hready=0. It therefore lags addr_sel by exactly one completed transfer.
- Wait states (hready=0) freeze addr_sel, data_sel, hmastlock, hgrant and the beat counter.
- Simultaneous requests resolve by round-robin order only; there is no fixed priority apart from the default-master fallback.
- An owner dropping hbusreq mid fixed burst keeps the grant until the last beat completes.
- hgrant is always exactly one-hot. addr_sel and data_sel never take the value 2'b11.

Test Plan:
- Idle bus → apply reset, then no requests, hready=1 → hgrant=001, addr_sel=00, data_sel=00, hmastlock=0 on every cycle.
- Single request → hbusreq=010 at edge 0, hready=1, htrans=IDLE → hgrant=010 after edge 1; addr_sel=01 after edge 2; data_sel=01 after edge 3.
- Round-robin rotation → hbusreq=111 held, SINGLE transfers, hready=1 → grant order master2, master3, master1, master2, with one change per permitted arbitration edge.
- Burst protection → master3 owns the bus, issues NONSEQ INCR4 then 3 SEQ beats, hbusreq=011 throughout → hgrant stays 100 until the 4th beat's edge, then moves to 001.
- Wait states and lock → master2 locked (hlock=010, hbusreq=010) with a competing hbusreq bit0, and hready=0 for 3 cycles → hgrant, addr_sel, data_sel and hmastlock frozen; hmastlock=1; grant stays 010 until hlock[1] drops.
- Mid-burst reset → assert hreset during beat 2 of a master3 INCR8 → next edge gives hgrant=001, addr_sel=00, data_sel=00, beat counter 0.
